// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and access-check helpers for the LSU memory port.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK,
        ST_REQ,
        ST_WAIT,
`ifdef LSU_MISALIGN_SPLIT_EN
        ST_REQ2,
        ST_WAIT2,
`endif
        ST_RESP
    } state_e;

    // Offset must be a multiple of the access size.
    function automatic logic misaligned(input size_e size, input logic [2:0] ofs);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return ofs[0];
            SZ_W:    return |ofs[1:0];
            default: return |ofs;
        endcase
    endfunction

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3, input logic rv64);
        if (we)
            return !((f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW) || (rv64 && (f3 == F3_SD)));
        return (f3 == 3'b111) || (!rv64 && ((f3 == F3_LD) || (f3 == F3_LWU)));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store shift / byte enables per beat, load extract, merge and extend.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]               funct3,
    input  logic [$clog2(XLEN/8)-1:0] ofs,
    input  logic                     beat,
    input  logic [XLEN-1:0]          wdata,
    input  logic [XLEN-1:0]          rdata_lo,
    input  logic [XLEN-1:0]          rdata_hi,
    output logic [XLEN/8-1:0]        be_c,
    output logic [XLEN-1:0]          wdata_c,
    output logic [XLEN-1:0]          rdata_c
);
    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned NB2 = 2 * NB;
    localparam int unsigned XW2 = 2 * XLEN;

    size_e          size;
    logic           sext;
    logic [NB2-1:0] mask;
    logic [NB2-1:0] be2;
    logic [XW2-1:0] wd2;
    logic [XW2-1:0] merged;

    assign size = size_e'(funct3[1:0]);
    assign sext = ~funct3[2];

    // Two-lane-wide views let a misaligned access spill into the next word.
    always_comb begin
        case (size)
            SZ_B:    mask = NB2'(8'h01);
            SZ_H:    mask = NB2'(8'h03);
            SZ_W:    mask = NB2'(8'h0F);
            default: mask = NB2'(8'hFF);
        endcase
        be2     = mask << ofs;
        wd2     = XW2'(wdata) << {ofs, 3'b000};
        merged  = {rdata_hi, rdata_lo} >> {ofs, 3'b000};
        be_c    = beat ? be2[NB2-1:NB] : be2[NB-1:0];
        wdata_c = beat ? wd2[XW2-1:XLEN] : wd2[XLEN-1:0];
        case (size)
            SZ_B:    rdata_c = sext ? XLEN'($signed(merged[7:0]))  : XLEN'(merged[7:0]);
            SZ_H:    rdata_c = sext ? XLEN'($signed(merged[15:0])) : XLEN'(merged[15:0]);
            SZ_W:    rdata_c = sext ? XLEN'($signed(merged[31:0])) : XLEN'(merged[31:0]);
            default: rdata_c = XLEN'(merged[63:0]);
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// LSU memory-port sequencer: one request at a time onto a valid/ready bus.
// Optional two-beat misaligned support via LSU_MISALIGN_SPLIT_EN.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err
);
    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFS_W = $clog2(NB);

    state_e            state, state_n;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic              accept, load_beat, finish, chk_fail, misal, illegal, beat;
    logic [OFS_W-1:0]  ofs;
    logic [ADDR_W-1:0] beat_addr;
    logic [NB-1:0]     lane_be;
    logic [XLEN-1:0]   lane_wdata, ld_data, rd_lo, rd_hi;

    assign ofs       = addr_q[OFS_W-1:0];
    assign misal     = misaligned(size_e'(f3_q[1:0]), 3'(ofs));
    assign illegal   = f3_illegal(we_q, f3_q, XLEN == 64);
    assign beat      = (state == ST_WAIT);
    assign beat_addr = {addr_q[ADDR_W-1:OFS_W], OFS_W'(0)} + (beat ? ADDR_W'(NB) : ADDR_W'(0));

`ifdef LSU_MISALIGN_SPLIT_EN
    logic            split_q;
    logic [XLEN-1:0] rdata_lo_q;
    assign chk_fail = illegal;
    assign rd_lo    = (state == ST_WAIT2) ? rdata_lo_q : mem_rdata;
    assign rd_hi    = (state == ST_WAIT2) ? mem_rdata : '0;
`else
    assign chk_fail = illegal | misal;
    assign rd_lo    = mem_rdata;
    assign rd_hi    = '0;
`endif

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .funct3   (f3_q),
        .ofs      (ofs),
        .beat     (beat),
        .wdata    (wdata_q),
        .rdata_lo (rd_lo),
        .rdata_hi (rd_hi),
        .be_c     (lane_be),
        .wdata_c  (lane_wdata),
        .rdata_c  (ld_data)
    );

    // Next-state and datapath strobes.
    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        load_beat = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: if (req_valid && req_ready) begin
                accept  = 1'b1;
                state_n = ST_CHK;
            end
            ST_CHK: if (chk_fail) begin
                state_n = ST_RESP;
            end else begin
                state_n   = ST_REQ;
                load_beat = 1'b1;
            end
            ST_REQ: if (mem_ready) state_n = ST_WAIT;
            ST_WAIT: if (mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (split_q && !mem_err) begin
                    state_n   = ST_REQ2;
                    load_beat = 1'b1;
                end else begin
                    state_n = ST_RESP;
                    finish  = 1'b1;
                end
`else
                state_n = ST_RESP;
                finish  = 1'b1;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_REQ2: if (mem_ready) state_n = ST_WAIT2;
            ST_WAIT2: if (mem_rvalid) begin
                state_n = ST_RESP;
                finish  = 1'b1;
            end
`endif
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q    <= 1'b0;
            rdata_lo_q <= '0;
`endif
        end else begin
            state     <= state_n;
            req_ready <= (state_n == ST_IDLE);
            rsp_valid <= (state_n == ST_RESP);
`ifdef LSU_MISALIGN_SPLIT_EN
            mem_valid <= (state_n == ST_REQ) || (state_n == ST_REQ2);
            if (state == ST_CHK) split_q <= misal;
            if (load_beat && beat) rdata_lo_q <= mem_rdata;
`else
            mem_valid <= (state_n == ST_REQ);
`endif
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (load_beat) begin
                mem_we    <= we_q;
                mem_addr  <= beat_addr;
                mem_wdata <= lane_wdata;
                mem_be    <= lane_be;
            end
            if (state == ST_CHK) begin
                rsp_err   <= chk_fail;
                rsp_rdata <= '0;
            end
            if (finish) begin
                rsp_err   <= mem_err;
                rsp_rdata <= (mem_err || we_q) ? '0 : ld_data;
            end
        end
    end

endmodule
